// File: rtl/hazard_bypass_unit_if.sv
// Bypass interface between decode and the hazard/bypass unit.
// The master (decode/pipeline control) drives the ID-stage instruction
// fields and the hold/flush controls. The slave (hazard_bypass_unit)
// returns the stall request and the EXE operand forwarding selects.
interface hazard_bypass_unit_if #(
  parameter int REG_FILE_LEN = 32,
  parameter int CNT_W        = 32
);
  localparam int RW = $clog2(REG_FILE_LEN);

  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [RW-1:0]    id_src_reg_1;
  logic [RW-1:0]    id_src_reg_2;
  logic             id_uses_src2;
  logic [RW-1:0]    id_dst_reg;
  logic             id_reg_write_enable;
  logic             id_is_load;

  logic             stall;
  logic             dep_src1;
  logic             dep_src2;
  logic [1:0]       fwd_sel_1;
  logic [1:0]       fwd_sel_2;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output hold, flush, id_valid, id_src_reg_1, id_src_reg_2, id_uses_src2,
           id_dst_reg, id_reg_write_enable, id_is_load,
    input  stall, dep_src1, dep_src2, fwd_sel_1, fwd_sel_2, stall_cycles
  );

  modport slave (
    input  hold, flush, id_valid, id_src_reg_1, id_src_reg_2, id_uses_src2,
           id_dst_reg, id_reg_write_enable, id_is_load,
    output stall, dep_src1, dep_src2, fwd_sel_1, fwd_sel_2, stall_cycles
  );
endinterface

// File: rtl/hazard_bypass_unit.sv
// Hazard detection and operand bypass control for a 5-stage
// IF/ID/EXE/MEM/WB pipeline.
//
// Two tracking slots mirror the writers currently in EXE (ex_s) and
// MEM (mem_s). The ID instruction's sources are compared against them:
// a hit in ex_s means the producer will be in MEM when the consumer is in
// EXE (select 1), a hit in mem_s means it will be in WB (select 2).
// A load in ex_s cannot forward from MEM, so its consumer stalls one
// cycle and picks the data up from WB instead.
//
// slot    | meaning
// ex_s    | instruction entering MEM on the next edge (now in EXE)
// mem_s   | instruction entering WB on the next edge (now in MEM)
module hazard_bypass_unit #(
  parameter int REG_FILE_LEN = 32,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_bypass_unit_if.slave bus
);
  localparam int RW = $clog2(REG_FILE_LEN);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] dst;
    logic          we;
    logic          load;
  } slot_t;

  slot_t            ex_s;
  slot_t            mem_s;
  logic [1:0]       fwd_sel_1_q;
  logic [1:0]       fwd_sel_2_q;
  logic             dep_src1_q;
  logic             dep_src2_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             ex_hit_1;
  logic             ex_hit_2;
  logic             mem_hit_1;
  logic             mem_hit_2;
  logic             stall_c;
  logic             advance;
  logic [1:0]       sel_1_nxt;
  logic [1:0]       sel_2_nxt;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic slot_writes(input slot_t s, input logic [RW-1:0] r);
    return s.valid && s.we && (s.dst == r) && (r != '0);
  endfunction

  // Dependency compare, load-use stall and forwarding-source selection.
  always_comb begin
    ex_hit_1  = slot_writes(ex_s, bus.id_src_reg_1);
    ex_hit_2  = slot_writes(ex_s, bus.id_src_reg_2);
    mem_hit_1 = slot_writes(mem_s, bus.id_src_reg_1);
    mem_hit_2 = slot_writes(mem_s, bus.id_src_reg_2);

    // Flush wins over stall: the ID instruction is being discarded anyway.
    stall_c = bus.id_valid && !bus.flush && ex_s.load &&
              (ex_hit_1 || (bus.id_uses_src2 && ex_hit_2));
    advance = bus.id_valid && !stall_c && !bus.flush;

    // Youngest writer (ex_s) takes priority over the older one (mem_s).
    sel_1_nxt = ex_hit_1 ? 2'd1 : (mem_hit_1 ? 2'd2 : 2'd0);
    if (!bus.id_uses_src2) begin
      sel_2_nxt = 2'd0;
    end else begin
      sel_2_nxt = ex_hit_2 ? 2'd1 : (mem_hit_2 ? 2'd2 : 2'd0);
    end
  end

  // Pipeline tracking slots, registered EXE selects and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s        <= '0;
      mem_s       <= '0;
      fwd_sel_1_q <= 2'd0;
      fwd_sel_2_q <= 2'd0;
      dep_src1_q  <= 1'b0;
      dep_src2_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else if (!bus.hold) begin
      mem_s <= ex_s;
      if (advance) begin
        ex_s        <= '{valid: 1'b1, dst: bus.id_dst_reg,
                         we: bus.id_reg_write_enable, load: bus.id_is_load};
        fwd_sel_1_q <= sel_1_nxt;
        fwd_sel_2_q <= sel_2_nxt;
        dep_src1_q  <= (sel_1_nxt != 2'd0);
        dep_src2_q  <= (sel_2_nxt != 2'd0);
      end else begin
        ex_s        <= '0;
        fwd_sel_1_q <= 2'd0;
        fwd_sel_2_q <= 2'd0;
        dep_src1_q  <= 1'b0;
        dep_src2_q  <= 1'b0;
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall        = stall_c;
  assign bus.dep_src1     = dep_src1_q;
  assign bus.dep_src2     = dep_src2_q;
  assign bus.fwd_sel_1    = fwd_sel_1_q;
  assign bus.fwd_sel_2    = fwd_sel_2_q;
  assign bus.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Directed bench for hazard_bypass_unit: a table of instruction vectors
// with hand-computed stall/select values, then hand-written sequences for
// hold, asynchronous reset mid-stall and counter saturation (CNT_W = 4).
module tb_hazard_bypass_unit;
  localparam int REG_FILE_LEN = 32;
  localparam int CNT_W        = 4;
  localparam int RW           = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_bypass_unit_if #(.REG_FILE_LEN(REG_FILE_LEN), .CNT_W(CNT_W)) bus ();

  hazard_bypass_unit #(.REG_FILE_LEN(REG_FILE_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          v;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
    logic          u2;
    logic [RW-1:0] d;
    logic          we;
    logic          ld;
    logic          fl;
    logic          e_st;
    logic [1:0]    e_sel1;
    logic [1:0]    e_sel2;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  function automatic vec_t mk(input logic v, input int s1, input int s2,
                              input logic u2, input int d, input logic we,
                              input logic ld, input logic fl, input logic e_st,
                              input int e_sel1, input int e_sel2);
    vec_t r;
    r.v = v; r.s1 = RW'(s1); r.s2 = RW'(s2); r.u2 = u2; r.d = RW'(d);
    r.we = we; r.ld = ld; r.fl = fl; r.e_st = e_st;
    r.e_sel1 = 2'(e_sel1); r.e_sel2 = 2'(e_sel2);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int s1, input int s2, input logic u2,
                       input int d, input logic we, input logic ld,
                       input logic fl, input logic hold);
    bus.id_valid            = v;
    bus.id_src_reg_1        = RW'(s1);
    bus.id_src_reg_2        = RW'(s2);
    bus.id_uses_src2        = u2;
    bus.id_dst_reg          = RW'(d);
    bus.id_reg_write_enable = we;
    bus.id_is_load          = ld;
    bus.flush               = fl;
    bus.hold                = hold;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic check_regs(input string tag, input int sel1, input int sel2, input int cnt);
    check({tag, " fwd_sel_1"}, 32'(bus.fwd_sel_1), 32'(sel1));
    check({tag, " fwd_sel_2"}, 32'(bus.fwd_sel_2), 32'(sel2));
    check({tag, " dep_src1"}, 32'(bus.dep_src1), 32'(sel1 != 0));
    check({tag, " dep_src2"}, 32'(bus.dep_src2), 32'(sel2 != 0));
    check({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'(cnt));
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            v  s1  s2 u2  d  we ld fl  st sel1 sel2
    tbl.push_back(mk(1,  1,  2, 1,  5, 1, 0, 0, 0, 0, 0)); // add x5,x1,x2
    tbl.push_back(mk(1,  5,  7, 1,  6, 1, 0, 0, 0, 1, 0)); // sub x6,x5,x7
    tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(1,  0,  0, 1,  5, 1, 0, 0, 0, 0, 0)); // add x5,x0,x0
    tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0)); // nop
    tbl.push_back(mk(1,  5,  5, 1,  8, 1, 0, 0, 0, 2, 2)); // or x8,x5,x5
    tbl.push_back(mk(1,  1,  3, 0,  3, 1, 1, 0, 0, 0, 0)); // lw x3,0(x1)
    tbl.push_back(mk(1,  3,  1, 1,  4, 1, 0, 0, 1, 0, 0)); // add x4,x3,x1 stall
    tbl.push_back(mk(1,  3,  1, 1,  4, 1, 0, 0, 0, 2, 0)); // re-presented
    tbl.push_back(mk(1,  1,  1, 1,  9, 1, 0, 0, 0, 0, 0)); // add x9,x1,x1
    tbl.push_back(mk(1,  2,  2, 1,  9, 1, 0, 0, 0, 0, 0)); // add x9,x2,x2
    tbl.push_back(mk(1,  9,  9, 1, 10, 1, 0, 0, 0, 1, 1)); // add x10,x9,x9
    tbl.push_back(mk(1,  1,  1, 1,  0, 1, 0, 0, 0, 0, 0)); // add x0,x1,x1
    tbl.push_back(mk(1,  0,  0, 1, 11, 1, 0, 0, 0, 0, 0)); // add x11,x0,x0
    tbl.push_back(mk(1, 11, 11, 0, 12, 1, 0, 0, 0, 1, 0)); // addi x12,x11
    tbl.push_back(mk(1,  1,  1, 0, 13, 1, 1, 0, 0, 0, 0)); // lw x13,0(x1)
    tbl.push_back(mk(1,  2, 13, 0, 14, 1, 0, 0, 0, 0, 0)); // addi x14,x2 (src2=x13 unused)
    tbl.push_back(mk(1,  1,  1, 0, 15, 1, 1, 0, 0, 0, 0)); // lw x15,0(x1)
    tbl.push_back(mk(1, 15, 15, 1, 16, 1, 0, 1, 0, 0, 0)); // add x16 flushed in stall slot
    tbl.push_back(mk(1, 15,  1, 1, 17, 1, 0, 0, 0, 2, 0)); // add x17,x15,x1

    do_reset();
    check("reset stall", 32'(bus.stall), 32'd0);
    check_regs("reset", 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, int'(tbl[i].s1), int'(tbl[i].s2), tbl[i].u2, int'(tbl[i].d),
            tbl[i].we, tbl[i].ld, tbl[i].fl, 1'b0);
      #1;
      check($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(tbl[i].e_st));
      tick();
      if (tbl[i].e_st) exp_cnt++;
      check_regs($sformatf("vec%0d", i), int'(tbl[i].e_sel1), int'(tbl[i].e_sel2), exp_cnt);
    end

    // Hold for three cycles while a load-use stall is pending.
    do_reset();
    drive(1, 2, 2, 1, 1, 1, 0, 0, 0); // add x1,x2,x2
    tick();
    drive(1, 1, 0, 0, 3, 1, 1, 0, 0); // lw x3,0(x1)
    tick();
    check_regs("hold pre", 1, 0, 0);
    drive(1, 3, 1, 1, 4, 1, 0, 0, 1); // add x4,x3,x1 with hold
    #1;
    check("hold stall comb", 32'(bus.stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold%0d stall", k), 32'(bus.stall), 32'd1);
      check_regs($sformatf("hold%0d", k), 1, 0, 0);
    end
    bus.hold = 1'b0;
    #1;
    check("release stall", 32'(bus.stall), 32'd1);
    tick();
    check_regs("release", 0, 0, 1);
    check("after release stall", 32'(bus.stall), 32'd0);
    tick();
    check_regs("load-use wb", 2, 0, 1);

    // Asynchronous reset in the middle of a stall cycle.
    drive(1, 2, 2, 1, 1, 1, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 3, 1, 1, 0, 0);
    tick();
    drive(1, 3, 1, 1, 4, 1, 0, 0, 0);
    #1;
    check("pre-rst stall", 32'(bus.stall), 32'd1);
    check_regs("pre-rst", 1, 0, 1);
    rst = 1'b1;
    #1;
    check("rst stall", 32'(bus.stall), 32'd0);
    check_regs("rst async", 0, 0, 0);
    tick();
    #2 rst = 1'b0;
    exp_cnt = 0;
    tick();

    // Counter saturation with a 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 0, 3, 1, 1, 0, 0); // lw x3,0(x1)
      #1;
      check($sformatf("sat%0d lw stall", k), 32'(bus.stall), 32'd0);
      tick();
      drive(1, 3, 1, 1, 4, 1, 0, 0, 0); // add x4,x3,x1
      #1;
      check($sformatf("sat%0d stall", k), 32'(bus.stall), 32'd1);
      tick();
      if (exp_cnt < 15) exp_cnt++;
      check($sformatf("sat%0d count", k), 32'(bus.stall_cycles), 32'(exp_cnt));
    end
    check("saturated count", 32'(bus.stall_cycles), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
